// File: rtl/stall_flush_ctrl_pkg.sv
// ============================================================================
// stall_flush_ctrl_pkg : shared types and constants for the hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package stall_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    EXC_FLUSH = 2'd2,
    EXC_FETCH = 2'd3
  } state_t;

  typedef logic [1:0] pc_src_t;

  localparam pc_src_t PC_SEQ    = 2'd0;
  localparam pc_src_t PC_BRANCH = 2'd1;
  localparam pc_src_t PC_EPC    = 2'd2;
  localparam pc_src_t PC_VECTOR = 2'd3;

  localparam int DIV_LATENCY_DEFAULT = 32;

endpackage

`default_nettype wire

// File: rtl/stall_flush_ctrl_if.sv
// ============================================================================
// stall_flush_ctrl_if : pipeline hazard inputs and stall/flush/PC-select outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface stall_flush_ctrl_if;
  import stall_flush_ctrl_pkg::*;

  logic    IF_MemReady;
  logic    M_MemReq;
  logic    M_MemReady;
  logic    M_Exception;
  logic    ID_LoadUse;
  logic    ID_BranchTaken;
  logic    ID_BLikelyCancel;
  logic    ID_ERET;
  logic    ID_UsesHiLo;
  logic    EX_MulDivStart;
  logic    IF_Stall;
  logic    ID_Stall;
  logic    EX_Stall;
  logic    M_Stall;
  logic    IF_Flush;
  logic    ID_Bubble;
  logic    ExceptionFlush;
  pc_src_t PCSrc;
  logic    MulDivBusy;

  // Pipeline side: reports hazards, consumes controls
  modport master (
    output IF_MemReady, M_MemReq, M_MemReady, M_Exception, ID_LoadUse,
           ID_BranchTaken, ID_BLikelyCancel, ID_ERET, ID_UsesHiLo, EX_MulDivStart,
    input  IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Bubble,
           ExceptionFlush, PCSrc, MulDivBusy
  );

  // Controller side
  modport slave (
    input  IF_MemReady, M_MemReq, M_MemReady, M_Exception, ID_LoadUse,
           ID_BranchTaken, ID_BLikelyCancel, ID_ERET, ID_UsesHiLo, EX_MulDivStart,
    output IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Bubble,
           ExceptionFlush, PCSrc, MulDivBusy
  );

endinterface

`default_nettype wire

// File: rtl/stall_flush_ctrl_muldiv_busy_cnt.sv
// ============================================================================
// muldiv_busy_cnt : MUL/DIV occupancy down-counter, reloaded on every start
// Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_busy_cnt
  import stall_flush_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic start,
  output logic      busy
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(DIV_LATENCY);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

`default_nettype wire

// File: rtl/stall_flush_ctrl.sv
// ============================================================================
// stall_flush_ctrl : 5-stage pipeline stall / flush / PC-select controller
// Rev 1.0
// ============================================================================
`default_nettype none

module stall_flush_ctrl
  import stall_flush_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  stall_flush_ctrl_if.slave bus
);

  state_t  state;
  state_t  state_next;
  logic    busy;
  logic    if_stall;
  logic    id_stall;
  logic    ex_stall;
  logic    m_stall;
  logic    if_flush;
  logic    id_bubble;
  logic    exc_flush;
  pc_src_t pc_src;

  muldiv_busy_cnt #(
    .DIV_LATENCY (DIV_LATENCY)
  ) u_busy_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .start (bus.EX_MulDivStart),
    .busy  (busy)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if_stall   = 1'b0;
    id_stall   = 1'b0;
    ex_stall   = 1'b0;
    m_stall    = 1'b0;
    if_flush   = 1'b0;
    id_bubble  = 1'b0;
    exc_flush  = 1'b0;
    pc_src     = PC_SEQ;

    case (state)
      RUN, DMEM_WAIT: begin
        if (bus.M_Exception) begin
          exc_flush  = 1'b1;
          pc_src     = PC_VECTOR;
          state_next = EXC_FLUSH;
        end else if (bus.M_MemReq && !bus.M_MemReady) begin
          if_stall   = 1'b1;
          id_stall   = 1'b1;
          ex_stall   = 1'b1;
          m_stall    = 1'b1;
          state_next = DMEM_WAIT;
        end else begin
          state_next = RUN;
          if ((bus.ID_UsesHiLo && busy) || bus.ID_LoadUse) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            id_bubble = 1'b1;
          end else begin
            // A fetch miss and an ID redirect can coexist: the PC updates while IF holds a NOP
            if (!bus.IF_MemReady) begin
              if_stall = 1'b1;
              if_flush = 1'b1;
            end
            if (bus.ID_BranchTaken) begin
              pc_src = PC_BRANCH;
            end else if (bus.ID_ERET) begin
              pc_src   = PC_EPC;
              if_flush = 1'b1;
            end else if (bus.ID_BLikelyCancel) begin
              if_flush = 1'b1;
            end
          end
        end
      end
      EXC_FLUSH: begin
        exc_flush  = 1'b1;
        state_next = EXC_FETCH;
      end
      EXC_FETCH: begin
        if (!bus.IF_MemReady) begin
          if_stall = 1'b1;
          if_flush = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    // Outputs are combinational in the inputs, so reset must mask them directly
    if (RST) begin
      if_stall  = 1'b0;
      id_stall  = 1'b0;
      ex_stall  = 1'b0;
      m_stall   = 1'b0;
      if_flush  = 1'b0;
      id_bubble = 1'b0;
      exc_flush = 1'b0;
      pc_src    = PC_SEQ;
    end
  end

  assign bus.IF_Stall       = if_stall;
  assign bus.ID_Stall       = id_stall;
  assign bus.EX_Stall       = ex_stall;
  assign bus.M_Stall        = m_stall;
  assign bus.IF_Flush       = if_flush;
  assign bus.ID_Bubble      = id_bubble;
  assign bus.ExceptionFlush = exc_flush;
  assign bus.PCSrc          = pc_src;
  assign bus.MulDivBusy     = busy;

endmodule

`default_nettype wire

// File: tb/tb_stall_flush_ctrl.sv
// ============================================================================
// tb_stall_flush_ctrl : directed vectors, scoreboard queue checked each negedge
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stall_flush_ctrl;

  // Input vector bits {IF_MemReady, M_MemReq, M_MemReady, M_Exception, ID_LoadUse,
  //                    ID_BranchTaken, ID_BLikelyCancel, ID_ERET, ID_UsesHiLo, EX_MulDivStart}
  localparam logic [9:0] IFR = 10'h200;
  localparam logic [9:0] MRQ = 10'h100;
  localparam logic [9:0] MRD = 10'h080;
  localparam logic [9:0] MEX = 10'h040;
  localparam logic [9:0] LU  = 10'h020;
  localparam logic [9:0] BT  = 10'h010;
  localparam logic [9:0] BL  = 10'h008;
  localparam logic [9:0] ER  = 10'h004;
  localparam logic [9:0] HL  = 10'h002;
  localparam logic [9:0] MS  = 10'h001;

  // Output vector bits {IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Bubble,
  //                     ExceptionFlush, PCSrc[1:0], MulDivBusy}
  localparam logic [9:0] NONE  = 10'h000;
  localparam logic [9:0] S_IF  = 10'h200;
  localparam logic [9:0] S_ID  = 10'h100;
  localparam logic [9:0] S_EX  = 10'h080;
  localparam logic [9:0] S_M   = 10'h040;
  localparam logic [9:0] F_IF  = 10'h020;
  localparam logic [9:0] BUB   = 10'h010;
  localparam logic [9:0] EF    = 10'h008;
  localparam logic [9:0] P_BR  = 10'h002;
  localparam logic [9:0] P_EPC = 10'h004;
  localparam logic [9:0] P_VEC = 10'h006;
  localparam logic [9:0] BUSY  = 10'h001;
  localparam logic [9:0] S_ALL = S_IF | S_ID | S_EX | S_M;
  localparam logic [9:0] HAZ   = S_IF | S_ID | BUB;

  typedef struct {
    logic [9:0] exp;
    string      name;
  } sb_item_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] in_vec = MEX | LU | BT | MS;
  logic [9:0] out_vec;
  sb_item_t   sb[$];
  int         total = 0;
  int         bad = 0;

  stall_flush_ctrl_if bus ();

  stall_flush_ctrl #(
    .DIV_LATENCY (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.IF_MemReady      = in_vec[9];
  assign bus.M_MemReq         = in_vec[8];
  assign bus.M_MemReady       = in_vec[7];
  assign bus.M_Exception      = in_vec[6];
  assign bus.ID_LoadUse       = in_vec[5];
  assign bus.ID_BranchTaken   = in_vec[4];
  assign bus.ID_BLikelyCancel = in_vec[3];
  assign bus.ID_ERET          = in_vec[2];
  assign bus.ID_UsesHiLo      = in_vec[1];
  assign bus.EX_MulDivStart   = in_vec[0];

  assign out_vec = {bus.IF_Stall, bus.ID_Stall, bus.EX_Stall, bus.M_Stall, bus.IF_Flush,
                    bus.ID_Bubble, bus.ExceptionFlush, bus.PCSrc, bus.MulDivBusy};

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      sb_item_t it;
      it = sb.pop_front();
      total++;
      if (out_vec !== it.exp) begin
        bad++;
        $display("FAIL %s: got %b want %b", it.name, out_vec, it.exp);
      end
    end
  end

  task automatic step(input logic [9:0] in, input logic [9:0] exp, input string name);
    sb_item_t it;
    @(posedge CLK);
    #1;
    in_vec = in;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic reset_pulse(input logic [9:0] in, input string name);
    sb_item_t it;
    @(posedge CLK);
    #1;
    in_vec = in;
    #1;
    RST = 1'b1;
    it.exp  = NONE;
    it.name = name;
    sb.push_back(it);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    in_vec = IFR;
  endtask

  initial begin
    step(MEX | LU | BT | MS, NONE, "reset_hold0");
    step(MEX | LU | BT | MS, NONE, "reset_hold1");
    @(negedge CLK);
    #1;
    RST    = 1'b0;
    in_vec = IFR;

    step(IFR,      NONE, "idle");
    step(IFR | LU, HAZ,  "load_use");
    step(IFR,      NONE, "load_use_after");

    for (int i = 0; i < 3; i++) step(IFR | MRQ, S_ALL, "dmem_wait");
    step(IFR | MRQ | MRD, NONE, "dmem_release");
    step(IFR | MRQ | LU,  S_ALL, "dmem_over_load_use");
    step(IFR | MRQ | MRD | LU, HAZ, "release_into_load_use");

    step(IFR | MRQ,       S_ALL,      "exc_enter_wait");
    step(IFR | MRQ | MEX, EF | P_VEC, "exc_in_wait");
    step(MEX | LU | BT,   EF,         "exc_flush_ignores");
    step(MEX,             S_IF | F_IF, "exc_fetch_miss0");
    step(NONE,            S_IF | F_IF, "exc_fetch_miss1");
    step(IFR,             NONE,        "exc_fetch_done");
    step(IFR | BT,        P_BR,        "branch_after_exc");

    step(IFR | MS, NONE, "md_start");
    for (int i = 0; i < 4; i++) step(IFR | HL, HAZ | BUSY, "md_hilo_stall");
    step(IFR | HL, NONE, "md_released");

    step(IFR | MS,      NONE,       "md_start2");
    step(IFR | HL,      HAZ | BUSY, "md_stall_pre_reload");
    step(IFR | HL | MS, HAZ | BUSY, "md_reload");
    for (int i = 0; i < 4; i++) step(IFR | HL, HAZ | BUSY, "md_stall_post_reload");
    step(IFR | HL, NONE, "md_released2");

    step(IFR | MS,  NONE,              "md_start3");
    step(IFR | MEX, EF | P_VEC | BUSY, "md_exc");
    step(IFR,       EF | BUSY,         "md_exc_flush");
    step(IFR,       BUSY,              "md_exc_fetch");
    step(IFR | HL,  HAZ | BUSY,        "md_survives_flush");
    step(IFR | HL,  NONE,              "md_released3");

    step(IFR | ER,       P_EPC | F_IF,        "eret");
    step(IFR | BL,       F_IF,                "blikely_cancel");
    step(BT,             S_IF | F_IF | P_BR,  "branch_fetch_miss");
    step(NONE,           S_IF | F_IF,         "fetch_miss");
    step(BT | ER,        S_IF | F_IF | P_BR,  "branch_over_eret");
    step(IFR | HL,       NONE,                "hilo_not_busy");

    step(IFR | MEX, EF | P_VEC,  "exc2");
    step(IFR,       EF,          "exc2_flush");
    step(NONE,      S_IF | F_IF, "exc2_fetch_miss");
    reset_pulse(LU | BT, "async_reset_mid_fetch");
    step(IFR | MEX, EF | P_VEC, "run_after_reset");
    step(IFR,       EF,         "exc3_flush");
    step(IFR,       NONE,       "exc3_fetch_done");

    @(posedge CLK);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 The block SHALL have one clock, CLK, and one reset, RST; RST SHALL be asynchronous and active-high.
REQ-002 Parameter DIV_LATENCY, default 32: the MUL/DIV busy period in cycles.
REQ-003 Ports, in order (name, direction, width, meaning):
- CLK in 1: clock.
- RST in 1: async active-high reset.
- IF_MemReady in 1: instruction fetch completes this cycle.
- M_MemReq in 1: the M-stage instruction accesses data memory.
- M_MemReady in 1: the data access completes this cycle.
- M_Exception in 1: the M-stage instruction raised an exception.
- ID_LoadUse in 1: load-use hazard detected in ID.
- ID_BranchTaken in 1: branch or jump resolved taken in ID.
- ID_BLikelyCancel in 1: Branch Likely resolved not-taken in ID.
- ID_ERET in 1: ERET in ID.
- ID_UsesHiLo in 1: ID reads HI/LO or issues MUL/DIV.
- EX_MulDivStart in 1: MUL/DIV issues from EX.
- IF_Stall, ID_Stall, EX_Stall, M_Stall out 1: per-stage hold.
- IF_Flush out 1: IF/ID loads a NOP.
- ID_Bubble out 1: ID/EX loads a NOP.
- ExceptionFlush out 1: flush IF/ID, ID/EX and EX/M.
- PCSrc out 2: 0 = PC+4, 1 = branch target, 2 = EPC, 3 = exception vector.
- MulDivBusy out 1: MUL/DIV unit is occupied.

Function
REQ-004 FSM states SHALL be RUN, DMEM_WAIT, EXC_FLUSH and EXC_FETCH.
REQ-005 Stall, flush and PCSrc outputs SHALL be combinational in state and inputs; MulDivBusy SHALL be registered.
REQ-006 In RUN and DMEM_WAIT, M_Exception SHALL take top priority:
- ExceptionFlush=1, PCSrc=3, all stalls 0.
- Next state EXC_FLUSH.
REQ-007 Otherwise, if M_MemReq & ~M_MemReady: all four stalls SHALL be 1, flushes 0, PCSrc 0, next state DMEM_WAIT.
REQ-008 In DMEM_WAIT, M_MemReady=1 SHALL release all stalls in the same cycle and return to RUN.
REQ-009 Otherwise, if ID_UsesHiLo & MulDivBusy: IF_Stall=ID_Stall=1 and ID_Bubble=1.
REQ-010 Otherwise, if ID_LoadUse: IF_Stall=ID_Stall=1 and ID_Bubble=1.
REQ-011 Otherwise, if ~IF_MemReady: IF_Stall=1 and IF_Flush=1; ID and later stages advance.
REQ-012 Lowest priority:
- ID_BranchTaken: PCSrc=1.
- ID_ERET: PCSrc=2 and IF_Flush=1 (delay slot discarded).
- ID_BLikelyCancel: IF_Flush=1.
- None of these: PCSrc=0.
REQ-013 ID_BranchTaken with ~IF_MemReady SHALL assert IF_Stall, IF_Flush and PCSrc=1 together.
REQ-014 EXC_FLUSH SHALL last exactly one cycle, then move to EXC_FETCH. In EXC_FLUSH:
- ExceptionFlush=1, PCSrc=0.
- All other inputs ignored.
REQ-015 In EXC_FETCH, IF_Stall=1 and IF_Flush=1 until IF_MemReady=1. That cycle, both deassert and the state returns to RUN.
REQ-016 A new M_Exception in EXC_FLUSH or EXC_FETCH SHALL be ignored, since the pipeline is already flushed.
REQ-017 MulDivBusy counter (width clog2(DIV_LATENCY+1)):
- EX_MulDivStart loads DIV_LATENCY.
- Otherwise the counter decrements while non-zero, saturating at 0.
- MulDivBusy = (count != 0).
- A start while busy SHALL reload.
- ExceptionFlush SHALL NOT clear the counter.
REQ-018 Stall outputs SHALL be monotone down the pipe (M_Stall implies EX_Stall implies ID_Stall implies IF_Stall) in every state.

Reset
REQ-019 While RST=1:
- state=RUN, counter=0.
- All outputs 0, PCSrc=0.
REQ-020 Reset asserted mid-DMEM_WAIT or mid-EXC_FETCH SHALL immediately force RUN with all outputs deasserted.

Structure
REQ-021 A shared package SHALL hold:
- The FSM state enum.
- PCSrc encodings PC_SEQ, PC_BRANCH, PC_EPC, PC_VECTOR.
- The DIV_LATENCY default.
REQ-022 The MUL/DIV busy counter SHALL be one sub-module, muldiv_busy_cnt; the FSM and priority logic remain in stall_flush_ctrl.

Verification
REQ-023 Load-use:
- Stimulus: ID_LoadUse=1 for one cycle in RUN.
- Response: IF_Stall=ID_Stall=ID_Bubble=1 that cycle, EX_Stall=M_Stall=0, all 0 the next cycle.
REQ-024 Data-memory wait:
- Stimulus: M_MemReq=1, M_MemReady=0 for 3 cycles, then 1.
- Response: all stalls 1 for 3 cycles, 0 in cycle 4, state RUN.
REQ-025 Exception during wait:
- Stimulus: DMEM_WAIT, then M_Exception=1.
- Response: ExceptionFlush=1, PCSrc=3 that cycle; ExceptionFlush=1, PCSrc=0 next cycle; EXC_FETCH with IF_Flush=1 until IF_MemReady.
REQ-026 MUL/DIV, DIV_LATENCY=4:
- Stimulus: EX_MulDivStart=1, then ID_UsesHiLo=1 held.
- Response: IF/ID stalled with ID_Bubble=1 for exactly 4 cycles, then released.
REQ-027 ERET and taken branch with fetch miss:
- ERET stimulus: ID_ERET=1 in RUN. Response: PCSrc=2, IF_Flush=1.
- Branch stimulus: ID_BranchTaken=1 with IF_MemReady=0. Response: PCSrc=1, IF_Stall=1, IF_Flush=1.
- Async reset: RST pulse mid-EXC_FETCH. Response: all outputs 0 before the next CLK edge.
